// File: rtl/psychic5_sound_cmd_tx.sv
// -----------------------------------------------------------------------------
// psychic5_sound_cmd_tx
//
// Main-CPU-side transmitter for the sound command channel. Command bytes
// written by the main CPU to the sound latch are queued in a small FIFO and
// presented one at a time as the sound code read by the sound CPU. A sound
// CPU read consumes the head entry when its strobe ends, so back-to-back
// commands are not lost the way they would be with a single latch.
//
// Both CPU buses are modelled as strobes sampled in the i_EMU_MCLK domain.
// Each strobe goes through a two-stage path:
//   stage 1: the strobe is registered (prev_*) and an edge is detected
//            against the live strobe; the edge is captured as a one-cycle
//            request (together with the write data for pushes).
//   stage 2: the request updates the FIFO, one clock later.
// A strobe first sampled low/high at edge N therefore takes effect at N+1.
//
// Ports
//   i_EMU_MCLK              system clock, all state on its rising edge
//   i_EMU_INITRST           asynchronous active-high reset
//   i_SOUNDCPU_FORCE_RST_n  0 = sound CPU held in reset; flushes the FIFO
//   i_MAINCPU_DIN[7:0]      main CPU write data
//   i_SOUNDLATCH_CS_n       main CPU sound latch select
//   i_MAINCPU_WR_n          main CPU write strobe (latch write = push)
//   i_MAINCPU_RD_n          main CPU read strobe (latch read = status)
//   o_STATUS_DOUT[7:0]      {overflow, 4'b0000, count[2:0]}
//   i_SOUNDCODE_CS_n        sound CPU sound-code select
//   i_SOUNDCPU_RD_n         sound CPU read strobe (end of read = pop)
//   o_SOUNDCODE[7:0]        FIFO head, 8'h00 when empty
//   o_SOUNDCODE_PENDING     1 while the FIFO holds at least one entry
// -----------------------------------------------------------------------------
module psychic5_sound_cmd_tx #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       i_EMU_MCLK,
  input  logic       i_EMU_INITRST,
  input  logic       i_SOUNDCPU_FORCE_RST_n,
  input  logic [7:0] i_MAINCPU_DIN,
  input  logic       i_SOUNDLATCH_CS_n,
  input  logic       i_MAINCPU_WR_n,
  input  logic       i_MAINCPU_RD_n,
  output logic [7:0] o_STATUS_DOUT,
  input  logic       i_SOUNDCODE_CS_n,
  input  logic       i_SOUNDCPU_RD_n,
  output logic [7:0] o_SOUNDCODE,
  output logic       o_SOUNDCODE_PENDING
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  // ---------------------------------------------------------------------------
  // Bus strobes (active low, combined with their selects)
  // ---------------------------------------------------------------------------
  logic wr_s;   // main CPU write to sound latch
  logic srd_s;  // sound CPU read of sound code
  logic mrd_s;  // main CPU read of status

  assign wr_s  = i_SOUNDLATCH_CS_n | i_MAINCPU_WR_n;
  assign srd_s = i_SOUNDCODE_CS_n  | i_SOUNDCPU_RD_n;
  assign mrd_s = i_SOUNDLATCH_CS_n | i_MAINCPU_RD_n;

  // ---------------------------------------------------------------------------
  // Stage 1: strobe history and edge requests
  // ---------------------------------------------------------------------------
  logic       prev_wr;
  logic       prev_srd;
  logic       prev_mrd;
  logic       wr_fall;
  logic       srd_rise;
  logic       mrd_rise;
  logic       push_req;
  logic       pop_req;
  logic       clr_req;
  logic [7:0] din_q;

  assign wr_fall  =  prev_wr  & ~wr_s;
  assign srd_rise = ~prev_srd &  srd_s;
  assign mrd_rise = ~prev_mrd &  mrd_s;

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge value of the others, independent of the
  // order in which the simulator evaluates the always blocks.
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      prev_wr  <= 1'b1;
      prev_srd <= 1'b1;
      prev_mrd <= 1'b1;
      push_req <= 1'b0;
      pop_req  <= 1'b0;
      clr_req  <= 1'b0;
      din_q    <= 8'h00;
    end else begin
      // History keeps tracking through a forced sound reset, so a strobe
      // already low when the reset is released is not seen as a new edge.
      prev_wr  <= wr_s;
      prev_srd <= srd_s;
      prev_mrd <= mrd_s;
      // Edges that occur while the sound side is held in reset are dropped
      // here, so a write that straddles the release never turns into a push.
      push_req <= wr_fall  & i_SOUNDCPU_FORCE_RST_n;
      pop_req  <= srd_rise & i_SOUNDCPU_FORCE_RST_n;
      clr_req  <= mrd_rise;
      // Data is captured on the same sample that sees the falling edge, so a
      // strobe only one sample wide still delivers the right byte.
      if (wr_fall) begin
        din_q <= i_MAINCPU_DIN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: FIFO update decisions
  // ---------------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;

  logic fifo_empty;
  logic fifo_full;
  logic do_push;
  logic do_pop;
  logic ovf_set;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == COUNT_FULL);

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    ovf_set = 1'b0;
    if (i_SOUNDCPU_FORCE_RST_n) begin
      // A pop on an empty FIFO is ignored, including when it coincides with
      // a push into the empty FIFO: the push lands, the pop does not.
      do_pop  = pop_req & ~fifo_empty;
      // A push into a full FIFO still succeeds when a pop frees a slot in
      // the same cycle; otherwise it is dropped and flagged.
      do_push = push_req & (~fifo_full | do_pop);
      ovf_set = push_req & fifo_full & ~do_pop;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!i_SOUNDCPU_FORCE_RST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The overflow flag survives a forced sound reset; only the main CPU
  // status read (or the system reset) clears it. A new overflow in the same
  // cycle as the clear keeps the flag set.
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_req) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately cleared by the asynchronous reset
  // so the head reads a defined 8'h00 afterwards; it is only a few bytes, so
  // a reset on every entry is cheap and keeps it out of RAM inference.
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= din_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (combinational from registers only)
  // ---------------------------------------------------------------------------
  logic [7:0] count_ext;

  assign count_ext           = 8'(count);
  assign o_SOUNDCODE         = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign o_SOUNDCODE_PENDING = ~fifo_empty;
  assign o_STATUS_DOUT       = {overflow, 4'b0000, count_ext[2:0]};

endmodule

// File: tb/tb_psychic5_sound_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_psychic5_sound_cmd_tx
//
// Drives main CPU writes/status reads and sound CPU reads as bus strobes.
// A reference model (byte queue + sticky overflow bit) predicts the FIFO
// contents; each sound CPU read pushes its expected byte into a scoreboard
// queue, and an independent monitor compares the byte held on o_SOUNDCODE
// during the read's low phase once the read strobe ends.
// -----------------------------------------------------------------------------
module tb_psychic5_sound_cmd_tx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       force_n;
  logic [7:0] din;
  logic       latch_cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       code_cs_n;
  logic       srd_n;
  logic [7:0] status;
  logic [7:0] code;
  logic       pending;

  psychic5_sound_cmd_tx #(.DEPTH_LOG2(2)) dut (
    .i_EMU_MCLK             (clk),
    .i_EMU_INITRST          (rst),
    .i_SOUNDCPU_FORCE_RST_n (force_n),
    .i_MAINCPU_DIN          (din),
    .i_SOUNDLATCH_CS_n      (latch_cs_n),
    .i_MAINCPU_WR_n         (wr_n),
    .i_MAINCPU_RD_n         (rd_n),
    .o_STATUS_DOUT          (status),
    .i_SOUNDCODE_CS_n       (code_cs_n),
    .i_SOUNDCPU_RD_n        (srd_n),
    .o_SOUNDCODE            (code),
    .o_SOUNDCODE_PENDING    (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [7:0] model_q[$];
  bit         model_ovf;
  // Scoreboard of bytes the sound CPU is expected to read
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_status();
    logic [2:0] cnt;
    cnt = 3'(model_q.size());
    return {model_ovf, 4'b0000, cnt};
  endfunction

  function automatic logic [7:0] model_head();
    return (model_q.size() == 0) ? 8'h00 : model_q[0];
  endfunction

  task automatic check_state(input string name);
    check({name, ".code"},    32'(code),    32'(model_head()));
    check({name, ".pending"}, 32'(pending), 32'(model_q.size() != 0));
    check({name, ".status"},  32'(status),  32'(model_status()));
  endtask

  // Model operations, stated directly from the queue semantics.
  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic model_read();
    if (model_q.size() == 0) exp_q.push_back(8'h00);
    else exp_q.push_back(model_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Bus tasks: inputs change on falling clock edges only
  // ---------------------------------------------------------------------------
  task automatic main_write(input logic [7:0] b, input int hold);
    model_push(b);
    @(negedge clk);
    latch_cs_n = 1'b0; din = b; wr_n = 1'b0;
    repeat (hold) @(negedge clk);
    wr_n = 1'b1; latch_cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic sound_read();
    model_read();
    @(negedge clk);
    code_cs_n = 1'b0; srd_n = 1'b0;
    repeat (2) @(negedge clk);
    code_cs_n = 1'b1; srd_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic status_read();
    @(negedge clk);
    latch_cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("status_rd", 32'(status), 32'(model_status()));
    @(negedge clk);
    rd_n = 1'b1; latch_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    model_ovf = 1'b0;
  endtask

  // Sound read ends on the same sample where a main CPU write begins.
  task automatic both_ops(input logic [7:0] b);
    if (model_q.size() == 0) begin
      exp_q.push_back(8'h00);
      model_q.push_back(b);
    end else begin
      exp_q.push_back(model_q.pop_front());
      model_q.push_back(b);
    end
    @(negedge clk);
    code_cs_n = 1'b0; srd_n = 1'b0;
    repeat (2) @(negedge clk);
    code_cs_n = 1'b1; srd_n = 1'b1;
    latch_cs_n = 1'b0; din = b; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    wr_n = 1'b1; latch_cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    force_n = 1'b0;
    @(negedge clk);
    force_n = 1'b1;
    repeat (2) @(negedge clk);
    model_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: captures o_SOUNDCODE while the sound read strobe is low and
  // checks it against the scoreboard when the strobe goes back high.
  // ---------------------------------------------------------------------------
  initial begin
    logic       was_low;
    logic [7:0] cap;
    logic [7:0] exp;
    was_low = 1'b0;
    cap     = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!(code_cs_n | srd_n)) begin
        cap     = code;
        was_low = 1'b1;
      end else if (was_low) begin
        was_low = 1'b0;
        if (exp_q.size() == 0) begin
          check("sound_read.unexpected", 32'(cap), 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("sound_read", 32'(cap), 32'(exp));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] b;
    int         r;

    rst = 1'b1; force_n = 1'b1; din = 8'h00;
    latch_cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    code_cs_n = 1'b1; srd_n = 1'b1;
    model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");

    // First push after reset
    main_write(8'h21, 2);
    check_state("push21");
    check("push21.status_lit", 32'(status), 32'h01);

    // Asynchronous reset mid-cycle, observed before any clock edge
    main_write(8'h33, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst.code",    32'(code),    32'h00);
    check("async_rst.pending", 32'(pending), 32'h0);
    check("async_rst.status",  32'(status),  32'h00);
    model_q.delete(); model_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_state("after_async_rst");

    // Order and pointer wrap
    for (int it = 0; it < 3; it++) begin
      main_write(8'h10, 2);
      main_write(8'h11, 1);
      main_write(8'h12, 3);
      check_state("order.filled");
      for (int k = 0; k < 3; k++) sound_read();
      check_state("order.drained");
    end

    // Full and overflow
    for (int k = 0; k < 5; k++) main_write(8'hA0 + 8'(k), 2);
    check_state("full");
    check("full.status_lit", 32'(status), 32'h84);
    status_read();
    check_state("full.status_cleared");

    // Simultaneous push and pop on a full FIFO
    both_ops(8'h55);
    check_state("both.full");
    for (int k = 0; k < 4; k++) sound_read();
    check_state("both.drained");

    // Simultaneous push and pop on an empty FIFO
    both_ops(8'h66);
    check_state("both.empty");
    sound_read();

    // Long write strobe and empty pops
    main_write(8'h77, 20);
    check_state("long_wr");
    sound_read();
    sound_read();
    check_state("empty_pop");

    // Flush with overflow set and three entries
    for (int k = 0; k < 5; k++) main_write(8'hC0 + 8'(k), 2);
    sound_read();
    check_state("pre_flush");
    flush_pulse();
    check_state("flush");

    // Write held across release of the forced reset
    @(negedge clk);
    force_n = 1'b0; latch_cs_n = 1'b0; din = 8'h99; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    force_n = 1'b1;
    repeat (3) @(negedge clk);
    wr_n = 1'b1; latch_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("wr_across_release");
    status_read();

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 11);
      b = 8'($urandom);
      if (r <= 4)       main_write(b, $urandom_range(1, 4));
      else if (r <= 8)  sound_read();
      else if (r == 9)  status_read();
      else if (r == 10) both_ops(b);
      else              flush_pulse();
      check_state("random");
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
